// File: rtl/line_prefetch.sv
// rtl/line_prefetch.sv - double-banked line buffer fed from frame memory, read out two lines behind
module line_prefetch #(
    parameter int CORDW     = 11,
    parameter int H_RES     = 1280,
    parameter int V_RES     = 720,
    parameter int ADDRW     = 20,
    parameter int BASE_ADDR = 0
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic [CORDW-1:0] sy_plus2,
    input  logic             de,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             line,
    input  logic             frame,
    output logic             mem_req,
    output logic [ADDRW-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [15:0]      pix_rgb,
    output logic             pix_de,
    output logic             pix_hsync,
    output logic             pix_vsync,
    output logic             pix_frame,
    output logic             fetch_busy,
    output logic             underrun
);
    localparam int WORDS = H_RES / 2;
    localparam int WIDXW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t           state_q, state_d;
    logic [CORDW-1:0] row_q, row_d;
    logic [WIDXW-1:0] widx_q, widx_d;
    logic             underrun_q, underrun_d;
    logic             xfer;

    assign xfer       = (state_q == FETCH) && mem_ack;
    assign mem_req    = (state_q == FETCH);
    assign fetch_busy = (state_q == FETCH);
    assign underrun   = underrun_q;
    assign mem_addr   = (state_q == FETCH)
                      ? ADDRW'(BASE_ADDR) + ADDRW'(row_q) * ADDRW'(WORDS) + ADDRW'(widx_q)
                      : '0;

    // A line strobe always wins: a fetch still running at that point is abandoned.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        widx_d     = widx_q;
        underrun_d = underrun_q;
        if (line) begin
            widx_d = '0;
            if (state_q == FETCH) underrun_d = 1'b1;
            if (sy_plus2 < CORDW'(V_RES)) begin
                state_d = FETCH;
                row_d   = sy_plus2;
            end else begin
                state_d = IDLE;
            end
        end else if (xfer) begin
            if (widx_q == WIDXW'(WORDS - 1)) begin
                state_d = DONE;
                widx_d  = '0;
            end else begin
                widx_d = widx_q + WIDXW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q    <= IDLE;
            row_q      <= '0;
            widx_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            widx_q     <= widx_d;
            underrun_q <= underrun_d;
        end
    end

    logic [31:0] bank0 [WORDS];
    logic [31:0] bank1 [WORDS];

    always_ff @(posedge clk_pix) begin
        if (xfer && !rst_pix) begin
            if (row_q[0]) bank1[widx_q] <= mem_rdata;
            else          bank0[widx_q] <= mem_rdata;
        end
    end

    logic             rd_bank_q, half_q;
    logic [CORDW-2:0] rd_addr_q;
    logic             de1_q, hs1_q, vs1_q, fr1_q;
    logic [15:0]      pix_rgb_q;
    logic             pix_de_q, pix_hs_q, pix_vs_q, pix_fr_q;
    logic [31:0]      rd_word;
    logic             unused_sy;

    assign unused_sy = &{1'b0, sy[CORDW-1:1]};
    assign rd_word   = rd_bank_q ? bank1[rd_addr_q] : bank0[rd_addr_q];

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            half_q    <= 1'b0;
            {de1_q, hs1_q, vs1_q, fr1_q} <= '0;
            pix_rgb_q <= '0;
            {pix_de_q, pix_hs_q, pix_vs_q, pix_fr_q} <= '0;
        end else begin
            rd_bank_q <= sy[0];
            rd_addr_q <= sx[CORDW-1:1];
            half_q    <= sx[0];
            {de1_q, hs1_q, vs1_q, fr1_q} <= {de, hsync, vsync, frame};
            pix_rgb_q <= de1_q ? (half_q ? rd_word[31:16] : rd_word[15:0]) : 16'h0000;
            {pix_de_q, pix_hs_q, pix_vs_q, pix_fr_q} <= {de1_q, hs1_q, vs1_q, fr1_q};
        end
    end

    assign pix_rgb   = pix_rgb_q;
    assign pix_de    = pix_de_q;
    assign pix_hsync = pix_hs_q;
    assign pix_vsync = pix_vs_q;
    assign pix_frame = pix_fr_q;
endmodule

// File: tb/tb_line_prefetch.sv
// tb/tb_line_prefetch.sv - scoreboard bench for line_prefetch
module tb_line_prefetch;
    logic        clk_pix = 1'b0;
    logic        rst_pix;
    logic [10:0] sx, sy, sy_plus2;
    logic        de, hsync, vsync, line, frame;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] pix_rgb;
    logic        pix_de, pix_hsync, pix_vsync, pix_frame;
    logic        fetch_busy, underrun;

    always #5 clk_pix = ~clk_pix;

    line_prefetch dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .sy_plus2(sy_plus2),
        .de(de), .hsync(hsync), .vsync(vsync), .line(line), .frame(frame),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pix_rgb(pix_rgb), .pix_de(pix_de), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync),
        .pix_frame(pix_frame), .fetch_busy(fetch_busy), .underrun(underrun)
    );

    // Memory model: garbage when not acking, a marker word at row 1 word 10.
    assign mem_rdata = !mem_ack ? 32'hDEAD_DEAD
                     : (mem_addr == 20'd650) ? 32'hBEEF_1234 : {12'hA5A, mem_addr};

    typedef struct {int cyc; logic [15:0] rgb;} pix_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [19:0] addr_exp [$];
    pix_t        pix_exp [$];

    always @(posedge clk_pix) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_pix) begin : monitor
        logic [19:0] ea;
        pix_t        ep;
        if (mem_req && mem_ack && !rst_pix) begin
            if (addr_exp.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_xfer: got addr %h expected no transfer", mem_addr);
            end else begin
                ea = addr_exp.pop_front();
                check("xfer_addr", 32'(mem_addr), 32'(ea));
            end
        end
        if (pix_de) begin
            if (pix_exp.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_pix: got %h expected no pixel", pix_rgb);
            end else begin
                ep = pix_exp.pop_front();
                check("pix_cycle", 32'(cyc), 32'(ep.cyc));
                check("pix_rgb", 32'(pix_rgb), 32'(ep.rgb));
            end
        end
    end

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic pulse(input int r);
        sy_plus2 = 11'(r);
        line     = 1'b1;
        step();
        line     = 1'b0;
    endtask

    task automatic fetch_rest(input int r, input int from);
        for (int k = from; k < 640; k++) begin
            addr_exp.push_back(20'(r * 640 + k));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_pix = 1'b1; sx = '0; sy = '0; sy_plus2 = 11'd5;
        de = 0; hsync = 0; vsync = 0; frame = 0; mem_ack = 1'b1;
        line = 1'b1;
        repeat (3) step();
        @(negedge clk_pix);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_busy", 32'(fetch_busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_pix_rgb", 32'(pix_rgb), 0);
        check("rst_pix_syncs", 32'({pix_de, pix_hsync, pix_vsync, pix_frame}), 0);
        rst_pix = 1'b0; line = 1'b0;
        step();

        // Row 5, ack always high.
        pulse(5);
        @(negedge clk_pix);
        check("busy_in_fetch", 32'(fetch_busy), 1);
        fetch_rest(5, 0);
        @(negedge clk_pix);
        check("row5_req_done", 32'(mem_req), 0);
        check("row5_busy_done", 32'(fetch_busy), 0);
        check("row5_underrun", 32'(underrun), 0);

        // Row 1 with a 3-cycle stall at word 10.
        pulse(1);
        fetch_rest_partial: for (k = 0; k < 10; k++) begin
            addr_exp.push_back(20'(640 + k));
            step();
        end
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk_pix);
            check("stall_addr", 32'(mem_addr), 650);
            check("stall_req", 32'(mem_req), 1);
            step();
        end
        mem_ack = 1'b1;
        fetch_rest(1, 10);

        // Readout of bank 1 word 10 with 2-cycle alignment.
        sy = 11'd1;
        sx = 11'd20; de = 1; hsync = 1; vsync = 1; frame = 1;
        pix_exp.push_back('{cyc + 2, 16'h1234});
        step();
        sx = 11'd21; de = 1; hsync = 0; vsync = 0; frame = 0;
        pix_exp.push_back('{cyc + 2, 16'hBEEF});
        @(negedge clk_pix);
        check("hsync_early", 32'({pix_hsync, pix_vsync, pix_frame}), 0);
        step();
        sx = 11'd20; de = 0;
        @(negedge clk_pix);
        check("syncs_delayed", 32'({pix_hsync, pix_vsync, pix_frame}), 32'b111);
        step();
        sx = 11'd0;
        @(negedge clk_pix);
        check("syncs_drop", 32'({pix_hsync, pix_vsync, pix_frame}), 0);
        step();
        @(negedge clk_pix);
        check("blank_de", 32'(pix_de), 0);
        check("blank_rgb", 32'(pix_rgb), 0);

        // Vertical blank lines never fetch.
        for (int r = 720; r <= 740; r++) begin
            pulse(r);
            @(negedge clk_pix);
            check("vblank_req", 32'(mem_req), 0);
        end
        pulse(0);
        fetch_rest(0, 0);
        @(negedge clk_pix);
        check("row0_req_done", 32'(mem_req), 0);

        // Slow memory: a new line arrives before row 10 completes.
        pulse(10);
        k = 0;
        for (int i = 0; i < 1360; i++) begin
            mem_ack = (i % 3 == 2);
            if (mem_ack) begin
                addr_exp.push_back(20'(6400 + k));
                k++;
            end
            step();
        end
        mem_ack = 1'b0;
        pulse(12);
        @(negedge clk_pix);
        check("underrun_set", 32'(underrun), 1);
        check("restart_addr", 32'(mem_addr), 7680);
        check("restart_req", 32'(mem_req), 1);
        mem_ack = 1'b1;
        fetch_rest(12, 0);
        @(negedge clk_pix);
        check("underrun_sticky", 32'(underrun), 1);
        check("row12_req_done", 32'(mem_req), 0);

        // Reset at word 100 of row 2.
        pulse(2);
        for (int j = 0; j < 100; j++) begin
            addr_exp.push_back(20'(1280 + j));
            step();
        end
        rst_pix = 1'b1;
        step();
        @(negedge clk_pix);
        check("midrst_req", 32'(mem_req), 0);
        check("midrst_busy", 32'(fetch_busy), 0);
        check("midrst_underrun", 32'(underrun), 0);
        check("midrst_addr", 32'(mem_addr), 0);
        rst_pix = 1'b0;
        step();
        step();

        check("addr_queue_drained", 32'(addr_exp.size()), 0);
        check("pix_queue_drained", 32'(pix_exp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
